// File: rtl/timer_counter_pkg.sv
// Shared types for the memory-mapped timer/counter: FSM states, register
// offsets, CTRL field layout and MODE encodings.
package timer_counter_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REG_CTRL   = 2'd0,
        REG_PRESET = 2'd1,
        REG_COUNT  = 2'd2,
        REG_RSVD   = 2'd3
    } reg_e;

    typedef enum logic [1:0] {
        MODE_ONESHOT = 2'b00,
        MODE_RELOAD  = 2'b01,
        MODE_RSVD2   = 2'b10,
        MODE_RSVD3   = 2'b11
    } mode_e;

    // CTRL layout: [3] IM, [2:1] MODE, [0] EN
    typedef struct packed {
        logic  im;
        mode_e mode;
        logic  en;
    } ctrl_t;

    // Only 01 reloads; the two unused encodings fall back to one-shot.
    function automatic logic is_reload(input mode_e mode);
        return mode == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Bus-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt flag.
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int unsigned ADDR_W = 30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wEn,
    input  logic [DATA_W-1:0] wData,
    output logic [DATA_W-1:0] rData,
    output logic              irq
);

    state_e            state_q,    state_d;
    ctrl_t             ctrl_q,     ctrl_d;
    logic [DATA_W-1:0] preset_q,   preset_d;
    logic [DATA_W-1:0] count_q,    count_d;
    logic              irq_flag_q, irq_flag_d;

    reg_e              reg_sel;
    logic              unused_addr_hi;

    // The bridge zeroes the address when unselected, so only the low bits decode.
    assign reg_sel        = reg_e'(addr[1:0]);
    assign unused_addr_hi = ^addr[ADDR_W-1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Period sequencing followed by software writes, so a CTRL write overrides
    // both the one-shot EN clear and any flag set in the same cycle.
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (count_q > DATA_W'(1)) begin
                    count_d = count_q - DATA_W'(1);
                end else begin
                    count_d    = '0;
                    irq_flag_d = 1'b1;
                    state_d    = ST_INT;
                end
            end
            ST_INT: begin
                state_d = ST_IDLE;
                if (is_reload(ctrl_q.mode)) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d.en = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wEn) begin
            case (reg_sel)
                REG_CTRL: begin
                    ctrl_d     = ctrl_t'(wData[CTRL_W-1:0]);
                    irq_flag_d = 1'b0;
                end
                REG_PRESET: begin
                    preset_d = wData;
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        rData = '0;
        case (reg_sel)
            REG_CTRL:   rData = DATA_W'(ctrl_q);
            REG_PRESET: rData = preset_q;
            REG_COUNT:  rData = count_q;
            default:    rData = '0;
        endcase
    end

    assign irq = irq_flag_q & ctrl_q.im;

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 30, the width of the word address supplied by the bus bridge (byte address bits [31:2]).
REQ-002 The module SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The module SHALL have port addr, input, ADDR_W, the word address; only addr[1:0] is decoded, since the bridge zeroes the address when the device is not selected.
REQ-005 The module SHALL have port wEn, input, 1, the full-word write strobe from the bridge.
REQ-006 The module SHALL have port wData, input, 32, the write data.
REQ-007 The module SHALL have port rData, output, 32, the combinational read data.
REQ-008 The module SHALL have port irq, output, 1, the interrupt request to the CPU interrupt logic.

Function
REQ-009 Register map (addr[1:0]): 0 = CTRL, 1 = PRESET, 2 = COUNT (read-only), 3 = reserved.
REQ-010 CTRL SHALL hold 4 bits: [0] EN, [2:1] MODE, [3] IM (interrupt mask); bits [31:4] SHALL read 0.
REQ-011 A write with wEn=1 SHALL update CTRL (wData[3:0]) or PRESET (wData[31:0]) at the next clock edge.
REQ-012 Writes to COUNT or reserved SHALL be ignored.
REQ-013 rData SHALL return the selected register combinationally, and SHALL return 0 for the reserved address.
REQ-014 The state machine SHALL have states IDLE, LOAD, CNT and INT.
REQ-015 IDLE SHALL go to LOAD when EN=1, and SHALL otherwise stay in IDLE.
REQ-016 LOAD SHALL set COUNT to PRESET and go to CNT, taking one cycle.
REQ-017 In CNT with EN=0, the block SHALL go to IDLE with COUNT held.
REQ-018 In CNT with EN=1 and COUNT>1, the block SHALL decrement COUNT by 1.
REQ-019 In CNT with EN=1 and COUNT<=1, the block SHALL set COUNT to 0, set the internal irq flag and go to INT.
REQ-020 INT SHALL always go to IDLE after one cycle.
REQ-021 If MODE=00 (one-shot), INT SHALL clear EN and the irq flag SHALL stay set.
REQ-022 If MODE=01 (auto-reload), EN SHALL stay 1 and the irq flag SHALL clear on leaving INT, giving a 1-cycle flag pulse; the next period restarts via IDLE->LOAD.
REQ-023 MODE values 10 and 11 SHALL behave as 00.
REQ-024 Period latency SHALL be: with PRESET=N>=1, the flag sets N+2 cycles after the EN write takes effect (IDLE, LOAD, then N CNT cycles).
REQ-025 PRESET=0 SHALL behave as PRESET=1.
REQ-026 irq SHALL equal irq_flag AND IM, with no extra register stage.
REQ-027 Any write to CTRL SHALL clear the irq flag.
REQ-028 On a same-cycle conflict, a software write to CTRL SHALL win over the INT-state clear of EN.
REQ-029 A PRESET write during CNT SHALL not alter the current COUNT; it SHALL take effect at the next LOAD.
REQ-030 COUNT arithmetic SHALL be 32-bit unsigned with no wrap below 0.

Reset
REQ-031 On reset=1, asynchronously: state SHALL be IDLE, and CTRL, PRESET, COUNT and irq_flag SHALL be 0, so rData=0 and irq=0.
REQ-032 Reset asserted mid-count SHALL abandon the period; after deassertion the block SHALL stay in IDLE until EN is written.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/LOAD/CNT/INT), register offsets (CTRL=0, PRESET=1, COUNT=2), CTRL field positions and MODE encodings.
REQ-034 The block SHALL be a single module with no sub-modules; two instances (Dev0 at 0x7F00, Dev1 at 0x7F10) SHALL be placed at the top level.

Verification
REQ-035 Reset, then read addr 0/1/2/3 -> all 0; irq=0.
REQ-036 Write PRESET=3, then CTRL=0x9 (EN, MODE 00, IM) -> COUNT reads 3,2,1,0 on successive CNT cycles; irq rises 5 cycles after the CTRL write edge and stays high; CTRL reads 0x8.
REQ-037 Continuing REQ-036, write CTRL=0x0 -> irq drops the next cycle and the state stays IDLE.
REQ-038 PRESET=2, CTRL=0xB (auto-reload) -> irq is a 1-cycle pulse every 5 cycles for at least 3 periods; EN stays 1.
REQ-039 During CNT with PRESET=10, write PRESET=4 -> the current period still expires after 10 counts, and the next period after 4.
REQ-040 Assert reset while COUNT=5 in CNT, and separately with IM=0 at expiry -> all registers return to 0; with IM=0, irq stays 0 while the internal flag behaves per mode.
